button_conditioner: RTL
=======================

// Module: button_conditioner
// PURPOSE
//  Front-end for the scoreboard's push-buttons: synchronises, debounces and
//  edge-detects N raw board buttons. Produces clean one-cycle press/release
//  pulses that drive the J/K inputs of the scoreboard flip-flop/counter bank
//  directly. One pulse per physical press means a J=K=1 command toggles the
//  flip-flop exactly once. Optional auto-repeat lets a held button step the
//  score or clock values.
// PARAMETERS
//  N               4      number of independent button channels
//  DEBOUNCE_CYCLES 50000  consecutive stable samples needed to accept a change (>=1)
//  REPEAT_EN       1      1 = held button emits repeated press pulses
//  REPEAT_DELAY    25000000 cycles from initial press to first repeat (>=1)
//  REPEAT_PERIOD   10000000 cycles between subsequent repeats (>=1)
//  ACTIVE_LOW      1      1 = raw button reads 0 when pressed
//  Counter widths are derived with $clog2 of the largest count held.
// PORTS
//  clk          in   1  system clock; all state changes on its rising edge
//  clr_n        in   1  asynchronous, active-low reset
//  btn_raw      in   N  raw, asynchronous button pins
//  btn_level    out  N  debounced state, 1 = pressed
//  btn_press    out  N  1-cycle pulse on accepted press and on each repeat
//  btn_release  out  N  1-cycle pulse on accepted release
// BEHAVIOUR
//  - Reset (clr_n=0, async):
//    - all outputs 0, every FSM in IDLE, all counters 0;
//    - sync flops load the inactive raw level (all 1s if ACTIVE_LOW).
//  - Sync: 2-flop synchroniser per bit.
//    - act = ACTIVE_LOW ? ~sync2 : sync2.
//    - act lags btn_raw by 2 edges.
//  - Per-channel FSM; channels are fully independent and identical.
//    - IDLE: act=1 -> PRESS_WAIT, cnt=1. Otherwise stay.
//    - PRESS_WAIT: act=0 -> IDLE, cnt=0, no pulse (bounce rejected).
//      act=1 and cnt==DEBOUNCE_CYCLES -> HELD, level<=1, press<=1, rep=0.
//      Otherwise cnt++.
//    - HELD: act=0 -> RELEASE_WAIT, cnt=1. Else, if REPEAT_EN, rep++.
//      Press pulse when rep reaches REPEAT_DELAY (first repeat), then every
//      REPEAT_PERIOD cycles after that.
//    - RELEASE_WAIT: act=1 -> HELD, cnt=0, no pulse; rep resumes, not cleared.
//      act=0 and cnt==DEBOUNCE_CYCLES -> IDLE, level<=0, release<=1.
//      Otherwise cnt++; rep frozen.
//  - Latency:
//    - raw change stable from before edge k: pulse and level change are
//      registered at edge k+1+DEBOUNCE_CYCLES;
//    - with DEBOUNCE_CYCLES=1 that is edge k+2.
//  - btn_press and btn_release are each high for exactly 1 cycle, never both
//    in the same cycle on one channel. No release pulse ever occurs without a
//    preceding press.
//  - Counters saturate, never wrap. rep restarts its period count after each
//    repeat pulse.
//  - Simultaneous events on several channels produce pulses in the same cycle.
//  - Reset mid-operation:
//    - outputs drop to 0 immediately;
//    - a button still held when clr_n rises is treated as a new press: full
//      sync plus debounce, then a press pulse;
//    - no release pulse is generated for the aborted press.
// TESTING (N=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, ACTIVE_LOW=1)
//  1 Clean press: btn_raw[0] 1->0 before edge 0, held 20 cycles
//    -> press[0] pulse at edge 5 only; level[0]=1 from edge 5;
//       channel 1 stays 0.
//  2 Bounce: btn_raw[0] toggles every 2 cycles for 16 cycles, then returns to 1
//    -> no press, no release; level[0] stays 0.
//  3 Release: from HELD, btn_raw[0] 0->1 before edge r, stable
//    -> release[0] pulse and level[0]=0 at edge r+5; no press pulse.
//  4 Auto-repeat: hold 30 cycles after initial press at edge p
//    -> extra press pulses at p+8, p+11, p+14, ...;
//       repeat with REPEAT_EN=0 -> exactly one press pulse.
//  5 Simultaneous: both raw bits fall before the same edge
//    -> press[1:0]=2'b11 in the same cycle; same for release.
//  6 Reset while HELD: clr_n=0 mid-cycle
//    -> all outputs 0 before the next edge;
//       clr_n=1 with button held -> press pulse 5 edges later,
//       no release pulse at any point.

Source files
------------

// File: rtl/button_conditioner.sv
// Button front-end: synchronises, debounces and edge-detects N raw buttons.
// Each channel produces a debounced level plus one-cycle press and release
// pulses. A held button can optionally emit repeated press pulses.
//
// Ports
//   clk          system clock, all state changes on its rising edge
//   clr_n        asynchronous active-low reset
//   btn_raw      raw asynchronous button pins
//   btn_level    debounced state, 1 = pressed
//   btn_press    one-cycle pulse on accepted press and on each auto-repeat
//   btn_release  one-cycle pulse on accepted release
//
// Debounce counting includes the sample that starts a change, so a change is
// accepted on the DEBOUNCE_CYCLES-th consecutive sample. A raw change that is
// stable before edge k first reaches the channel logic at edge k+2 and is
// accepted at edge k+1+DEBOUNCE_CYCLES.
module button_conditioner #(
    parameter int unsigned N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release
);

    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    // Last count value before a change is accepted / a repeat fires.
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
    localparam logic [REP_W-1:0] REP_SAT     = {REP_W{1'b1}};

    // Raw level of a released button; the synchroniser resets to it.
    localparam logic [N-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] act;

    // Two-flop synchroniser for every button bit.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Normalise polarity: act = 1 means the button is pressed.
    assign act = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    for (genvar ch = 0; ch < int'(N); ch++) begin : g_ch

        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [REP_W-1:0] rep_q, rep_d;
        logic             periodic_q, periodic_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             rep_fire_c;

        // Repeat fires once the held count reaches the current target:
        // the initial delay first, then the period between repeats.
        always_comb begin
            rep_fire_c = 1'b0;
            if (REPEAT_EN != 0) begin
                if (periodic_q) begin
                    rep_fire_c = (rep_q >= PERIOD_LAST);
                end else begin
                    rep_fire_c = (rep_q >= DELAY_LAST);
                end
            end
        end

        // Channel state register.
        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                rep_q      <= '0;
                periodic_q <= 1'b0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                rep_q      <= rep_d;
                periodic_q <= periodic_d;
                level_q    <= level_d;
                press_q    <= press_d;
                release_q  <= release_d;
            end
        end

        // Debounce / repeat next-state logic.
        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            rep_d      = rep_q;
            periodic_d = periodic_q;
            level_d    = level_q;
            press_d    = 1'b0;
            release_d  = 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (act[ch]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            // Single-sample debounce accepts immediately.
                            state_d    = HELD;
                            cnt_d      = '0;
                            level_d    = 1'b1;
                            press_d    = 1'b1;
                            rep_d      = '0;
                            periodic_d = 1'b0;
                        end else begin
                            state_d = PRESS_WAIT;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end

                PRESS_WAIT: begin
                    if (!act[ch]) begin
                        // Bounce rejected, nothing reported.
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= DB_LAST) begin
                        state_d    = HELD;
                        cnt_d      = '0;
                        level_d    = 1'b1;
                        press_d    = 1'b1;
                        rep_d      = '0;
                        periodic_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                HELD: begin
                    if (!act[ch]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d   = IDLE;
                            cnt_d     = '0;
                            level_d   = 1'b0;
                            release_d = 1'b1;
                        end else begin
                            state_d = RELEASE_WAIT;
                            cnt_d   = CNT_W'(1);
                        end
                    end else if (REPEAT_EN != 0) begin
                        if (rep_fire_c) begin
                            press_d    = 1'b1;
                            rep_d      = '0;
                            periodic_d = 1'b1;
                        end else if (rep_q != REP_SAT) begin
                            rep_d = rep_q + REP_W'(1);
                        end
                    end
                end

                RELEASE_WAIT: begin
                    // rep stays frozen here and resumes if the release bounces.
                    if (act[ch]) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q >= DB_LAST) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign btn_level[ch]   = level_q;
        assign btn_press[ch]   = press_q;
        assign btn_release[ch] = release_q;
    end

endmodule
